hdlc_rx_frame_buffer: RTL and testbench

Parametrised receive frame buffer between the HDLC Rx channel and the register-read interface. It generalises the fixed single-frame, 128-byte Rx buffer into a packet FIFO with configurable byte depth, maximum frame length and number of queued frames. Bytes of the frame in progress are written speculatively and committed on end-of-frame, or discarded on abort or FCS error. Committed frames are read out in order, one byte per read strobe.

---
 rtl/hdlc_rx_frame_buffer.sv | 185 ++++++++++++++++++
 tb/tb_hdlc_rx_frame_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_rx_frame_buffer
// Purpose  : HDLC receive packet FIFO. Bytes of the frame in progress are
//            written speculatively and committed on end-of-frame, or rewound
//            on abort/FCS error. Committed frames are read in order, one byte
//            per read strobe, with a show-ahead head byte.
// Revision : 1.0 - initial release
// ============================================================================
module hdlc_rx_frame_buffer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 256,
    parameter int MAX_FRAME = 128,
    parameter int FRAMES    = 4
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Rx_NewByte,
    input  logic [DATA_W-1:0]              Rx_Data,
    input  logic                           Rx_EoF,
    input  logic                           Rx_AbortSignal,
    input  logic                           Rx_FrameError,
    input  logic                           Rx_RdBuff,
    input  logic                           Rx_Drop,
    output logic                           Rx_Ready,
    output logic [$clog2(MAX_FRAME+1)-1:0] Rx_FrameSize,
    output logic [DATA_W-1:0]              DataOut,
    output logic [$clog2(FRAMES+1)-1:0]    Rx_FrameCnt,
    output logic                           Rx_Overflow
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int LEN_W  = $clog2(MAX_FRAME + 1);
    localparam int CNT_W  = $clog2(FRAMES + 1);
    localparam int FAW    = $clog2(FRAMES);
    localparam int FPTR_W = FAW + 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem      [DEPTH];
    logic [LEN_W-1:0]  size_mem [FRAMES];

    logic [PTR_W-1:0]  wr_ptr, commit_ptr, rd_ptr;
    logic [LEN_W-1:0]  cur_len;
    logic              ovf;
    logic [FPTR_W-1:0] sz_wr, sz_rd;
    state_t            state;
    logic [LEN_W-1:0]  head_rem;

    logic [PTR_W-1:0]  used;
    logic              accept;
    logic [PTR_W-1:0]  wr_ptr_nx;
    logic [LEN_W-1:0]  len_nx;
    logic              ovf_nx;
    logic              discard;
    logic              frames_full;
    logic              reject;
    logic              push;
    logic              sz_empty;
    logic              release_head;

    // Write-side and head-release decisions for this cycle. The incoming byte
    // is accounted for first so that a byte arriving with EoF obeys the limits.
    // Frame capacity counts the head frame too, so the size FIFO never overfills.
    always_comb begin
        used         = wr_ptr - rd_ptr;
        accept       = Rx_NewByte && (cur_len < LEN_W'(MAX_FRAME)) && (used != PTR_W'(DEPTH));
        wr_ptr_nx    = wr_ptr + PTR_W'(accept);
        len_nx       = cur_len + LEN_W'(accept);
        ovf_nx       = ovf | (Rx_NewByte & ~accept);
        discard      = Rx_AbortSignal | Rx_FrameError;
        frames_full  = (Rx_FrameCnt == CNT_W'(FRAMES));
        reject       = ~discard & Rx_EoF & (ovf_nx | frames_full);
        push         = ~discard & Rx_EoF & ~ovf_nx & ~frames_full & (len_nx != '0);
        sz_empty     = (sz_wr == sz_rd);
        release_head = (state == ACTIVE) &&
                       (Rx_Drop || (Rx_RdBuff && head_rem == LEN_W'(1)));
    end

    // Frame-in-progress tracking: speculative write pointer, commit, rewind.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            cur_len     <= '0;
            ovf         <= 1'b0;
            sz_wr       <= '0;
            Rx_Overflow <= 1'b0;
        end else begin
            Rx_Overflow <= 1'b0;
            if (discard) begin
                wr_ptr  <= commit_ptr;
                cur_len <= '0;
                ovf     <= 1'b0;
            end else if (Rx_EoF) begin
                if (reject) begin
                    wr_ptr      <= commit_ptr;
                    Rx_Overflow <= 1'b1;
                end else if (push) begin
                    wr_ptr     <= wr_ptr_nx;
                    commit_ptr <= wr_ptr_nx;
                    sz_wr      <= sz_wr + FPTR_W'(1);
                end
                cur_len <= '0;
                ovf     <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr_nx;
                cur_len <= len_nx;
                ovf     <= ovf_nx;
            end
        end
    end

    // Byte and frame-size storage; contents need no reset.
    always_ff @(posedge Clk) begin
        if (accept)
            mem[wr_ptr[AW-1:0]] <= Rx_Data;
        if (push)
            size_mem[sz_wr[FAW-1:0]] <= len_nx;
    end

    // Head-frame state machine: load the next committed size, then pop or drop.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            sz_rd        <= '0;
            head_rem     <= '0;
            Rx_FrameSize <= '0;
            Rx_Ready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!sz_empty) begin
                        Rx_FrameSize <= size_mem[sz_rd[FAW-1:0]];
                        head_rem     <= size_mem[sz_rd[FAW-1:0]];
                        sz_rd        <= sz_rd + FPTR_W'(1);
                        Rx_Ready     <= 1'b1;
                        state        <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (Rx_Drop) begin
                        rd_ptr       <= rd_ptr + PTR_W'(head_rem);
                        head_rem     <= '0;
                        Rx_FrameSize <= '0;
                        Rx_Ready     <= 1'b0;
                        state        <= IDLE;
                    end else if (Rx_RdBuff) begin
                        rd_ptr   <= rd_ptr + PTR_W'(1);
                        head_rem <= head_rem - LEN_W'(1);
                        if (head_rem == LEN_W'(1)) begin
                            Rx_FrameSize <= '0;
                            Rx_Ready     <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Committed-frame count: up on commit, down when the head frame is released.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Rx_FrameCnt <= '0;
        end else if (push && !release_head) begin
            Rx_FrameCnt <= Rx_FrameCnt + CNT_W'(1);
        end else if (release_head && !push) begin
            Rx_FrameCnt <= Rx_FrameCnt - CNT_W'(1);
        end
    end

    // Show-ahead head byte, forced to zero when no frame is presented.
    always_comb begin
        DataOut = Rx_Ready ? mem[rd_ptr[AW-1:0]] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_hdlc_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdlc_rx_frame_buffer
// Purpose  : Directed self-checking bench for hdlc_rx_frame_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdlc_rx_frame_buffer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx_NewByte = 1'b0;
    logic [7:0] Rx_Data = 8'h00;
    logic       Rx_EoF = 1'b0;
    logic       Rx_AbortSignal = 1'b0;
    logic       Rx_FrameError = 1'b0;
    logic       Rx_RdBuff = 1'b0;
    logic       Rx_Drop = 1'b0;
    logic       Rx_Ready;
    logic [7:0] Rx_FrameSize;
    logic [7:0] DataOut;
    logic [2:0] Rx_FrameCnt;
    logic       Rx_Overflow;

    int checks = 0;
    int errors = 0;
    int ovf_pulses = 0;

    hdlc_rx_frame_buffer #(
        .DATA_W(8), .DEPTH(256), .MAX_FRAME(128), .FRAMES(4)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data), .Rx_EoF(Rx_EoF),
        .Rx_AbortSignal(Rx_AbortSignal), .Rx_FrameError(Rx_FrameError),
        .Rx_RdBuff(Rx_RdBuff), .Rx_Drop(Rx_Drop),
        .Rx_Ready(Rx_Ready), .Rx_FrameSize(Rx_FrameSize), .DataOut(DataOut),
        .Rx_FrameCnt(Rx_FrameCnt), .Rx_Overflow(Rx_Overflow)
    );

    always #5 Clk = ~Clk;

    // Count overflow pulses, sampled mid-cycle.
    always @(negedge Clk) if (Rx_Overflow === 1'b1) ovf_pulses++;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic eof);
        Rx_NewByte = 1'b1; Rx_Data = d; Rx_EoF = eof;
        tick();
        Rx_NewByte = 1'b0; Rx_Data = 8'h00; Rx_EoF = 1'b0;
    endtask

    task automatic pop();
        Rx_RdBuff = 1'b1;
        tick();
        Rx_RdBuff = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (Rx_Ready !== 1'b1 && n < budget) begin tick(); n++; end
        checks++;
        if (Rx_Ready !== 1'b1) begin errors++; $display("FAIL wait_ready timeout: ready=%b required 1", Rx_Ready); end
    endtask

    task automatic drain_all();
        for (int i = 0; i < 20; i++) begin
            if (Rx_Ready === 1'b1) begin Rx_Drop = 1'b1; tick(); Rx_Drop = 1'b0; end
            else tick();
        end
        checks++;
        if (Rx_FrameCnt !== 3'd0 || Rx_Ready !== 1'b0) begin
            errors++; $display("FAIL drain: cnt=%0d ready=%b required 0 0", Rx_FrameCnt, Rx_Ready);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        #2;
        checks++;
        if ({Rx_Ready, Rx_FrameSize, DataOut, Rx_FrameCnt, Rx_Overflow} !== 20'h0) begin
            errors++; $display("FAIL reset outputs: ready=%b size=%0d data=%h cnt=%0d ovf=%b required all 0",
                               Rx_Ready, Rx_FrameSize, DataOut, Rx_FrameCnt, Rx_Overflow);
        end
        tick(); tick();
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b1);
        checks++;
        if (Rx_FrameCnt !== 3'd1 || Rx_Ready !== 1'b0) begin
            errors++; $display("FAIL basic after EoF: cnt=%0d ready=%b required 1 0", Rx_FrameCnt, Rx_Ready);
        end
        tick();
        checks++;
        if (Rx_Ready !== 1'b1 || Rx_FrameSize !== 8'd3) begin
            errors++; $display("FAIL basic ready: ready=%b size=%0d required 1 3", Rx_Ready, Rx_FrameSize);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (DataOut !== exp[i]) begin
                errors++; $display("FAIL basic data[%0d]: got %h required %h", i, DataOut, exp[i]);
            end
            pop();
        end
        checks++;
        if (Rx_Ready !== 1'b0 || Rx_FrameCnt !== 3'd0 || DataOut !== 8'h00 || Rx_FrameSize !== 8'd0) begin
            errors++; $display("FAIL basic drained: ready=%b cnt=%0d data=%h size=%0d required 0 0 00 0",
                               Rx_Ready, Rx_FrameCnt, DataOut, Rx_FrameSize);
        end
    endtask

    task automatic test_abort();
        int ovf0 = ovf_pulses;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        Rx_AbortSignal = 1'b1; tick(); Rx_AbortSignal = 1'b0;
        // byte with EoF and FCS error together: discard wins, no frame
        Rx_FrameError = 1'b1; send_byte(8'h66, 1'b1); Rx_FrameError = 1'b0;
        tick();
        checks++;
        if (Rx_FrameCnt !== 3'd0 || Rx_Ready !== 1'b0) begin
            errors++; $display("FAIL abort no frame: cnt=%0d ready=%b required 0 0", Rx_FrameCnt, Rx_Ready);
        end
        send_byte(8'h55, 1'b1);
        tick();
        checks++;
        if (Rx_Ready !== 1'b1 || Rx_FrameSize !== 8'd1 || DataOut !== 8'h55) begin
            errors++; $display("FAIL abort frame: ready=%b size=%0d data=%h required 1 1 55", Rx_Ready, Rx_FrameSize, DataOut);
        end
        pop();
        checks++;
        if (ovf_pulses != ovf0 || Rx_FrameCnt !== 3'd0) begin
            errors++; $display("FAIL abort ovf: pulses=%0d cnt=%0d required 0 0", ovf_pulses - ovf0, Rx_FrameCnt);
        end
    endtask

    task automatic test_overflow();
        int ovf0 = ovf_pulses;
        for (int i = 0; i < 130; i++) send_byte(8'(i), 1'b0);
        Rx_EoF = 1'b1; tick(); Rx_EoF = 1'b0;
        checks++;
        if (Rx_Overflow !== 1'b1 || Rx_FrameCnt !== 3'd0) begin
            errors++; $display("FAIL overflow pulse: ovf=%b cnt=%0d required 1 0", Rx_Overflow, Rx_FrameCnt);
        end
        tick();
        checks++;
        if (Rx_Overflow !== 1'b0 || Rx_Ready !== 1'b0 || ovf_pulses != ovf0 + 1) begin
            errors++; $display("FAIL overflow after: ovf=%b ready=%b pulses=%0d required 0 0 1",
                               Rx_Overflow, Rx_Ready, ovf_pulses - ovf0);
        end
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b1);
        tick();
        checks++;
        if (Rx_Ready !== 1'b1 || Rx_FrameSize !== 8'd2 || DataOut !== 8'h5A) begin
            errors++; $display("FAIL overflow next frame: ready=%b size=%0d data=%h required 1 2 5a", Rx_Ready, Rx_FrameSize, DataOut);
        end
        pop();
        checks++;
        if (DataOut !== 8'hA5) begin errors++; $display("FAIL overflow byte2: got %h required a5", DataOut); end
        pop();
    endtask

    task automatic test_frames_full();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        checks++;
        if (Rx_Overflow !== 1'b1 || Rx_FrameCnt !== 3'd4) begin
            errors++; $display("FAIL full fifth: ovf=%b cnt=%0d required 1 4", Rx_Overflow, Rx_FrameCnt);
        end
        checks++;
        if (Rx_Ready !== 1'b1 || DataOut !== 8'h01) begin
            errors++; $display("FAIL full head: ready=%b data=%h required 1 01", Rx_Ready, DataOut);
        end
        Rx_Drop = 1'b1; tick(); Rx_Drop = 1'b0;
        checks++;
        if (Rx_Ready !== 1'b0 || Rx_FrameCnt !== 3'd3) begin
            errors++; $display("FAIL full drop: ready=%b cnt=%0d required 0 3", Rx_Ready, Rx_FrameCnt);
        end
        tick();
        checks++;
        if (Rx_Ready !== 1'b1 || DataOut !== 8'h02 || Rx_FrameSize !== 8'd1) begin
            errors++; $display("FAIL full next head: ready=%b data=%h size=%0d required 1 02 1", Rx_Ready, DataOut, Rx_FrameSize);
        end
        drain_all();
    endtask

    task automatic test_back_to_back();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b1);
        wait_ready(5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (DataOut !== 8'(8'h31 + i)) begin
                errors++; $display("FAIL b2b frame1[%0d]: got %h required %h", i, DataOut, 8'(8'h31 + i));
            end
            Rx_RdBuff = 1'b1; Rx_NewByte = 1'b1; Rx_Data = 8'(8'h41 + i); Rx_EoF = (i == 2);
            tick();
        end
        Rx_RdBuff = 1'b0; Rx_NewByte = 1'b0; Rx_Data = 8'h00; Rx_EoF = 1'b0;
        checks++;
        if (Rx_Ready !== 1'b0 || Rx_FrameCnt !== 3'd1) begin
            errors++; $display("FAIL b2b gap: ready=%b cnt=%0d required 0 1", Rx_Ready, Rx_FrameCnt);
        end
        tick();
        checks++;
        if (Rx_Ready !== 1'b1 || Rx_FrameSize !== 8'd3 || DataOut !== 8'h41) begin
            errors++; $display("FAIL b2b frame2: ready=%b size=%0d data=%h required 1 3 41", Rx_Ready, Rx_FrameSize, DataOut);
        end
        pop();
        checks++;
        if (DataOut !== 8'h42) begin errors++; $display("FAIL b2b frame2[1]: got %h required 42", DataOut); end
        pop();
        checks++;
        if (DataOut !== 8'h43) begin errors++; $display("FAIL b2b frame2[2]: got %h required 43", DataOut); end
        pop();
        checks++;
        if (Rx_Ready !== 1'b0 || Rx_FrameCnt !== 3'd0) begin
            errors++; $display("FAIL b2b end: ready=%b cnt=%0d required 0 0", Rx_Ready, Rx_FrameCnt);
        end
    endtask

    task automatic test_async_reset();
        send_byte(8'h77, 1'b1);
        wait_ready(5);
        send_byte(8'h88, 1'b0);
        Rst = 1'b0;
        #1;
        checks++;
        if ({Rx_Ready, Rx_FrameSize, DataOut, Rx_FrameCnt, Rx_Overflow} !== 20'h0) begin
            errors++; $display("FAIL async reset: ready=%b size=%0d data=%h cnt=%0d ovf=%b required all 0",
                               Rx_Ready, Rx_FrameSize, DataOut, Rx_FrameCnt, Rx_Overflow);
        end
        tick();
        Rst = 1'b1;
        tick();
        send_byte(8'h99, 1'b1);
        tick();
        checks++;
        if (Rx_Ready !== 1'b1 || Rx_FrameSize !== 8'd1 || DataOut !== 8'h99 || Rx_FrameCnt !== 3'd1) begin
            errors++; $display("FAIL post reset frame: ready=%b size=%0d data=%h cnt=%0d required 1 1 99 1",
                               Rx_Ready, Rx_FrameSize, DataOut, Rx_FrameCnt);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_overflow();
        test_frames_full();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
